// File: rtl/time_counter.sv
// time_counter: 24-hour BCD hh:mm counter with validated load and day-rollover pulse
module time_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic [3:0] new_current_time_ms_hr,
  input  logic [3:0] new_current_time_ls_hr,
  input  logic [3:0] new_current_time_ms_min,
  input  logic [3:0] new_current_time_ls_min,
  output logic [3:0] current_time_ms_hr,
  output logic [3:0] current_time_ls_hr,
  output logic [3:0] current_time_ms_min,
  output logic [3:0] current_time_ls_min,
  output logic       day_rollover,
  output logic       load_error
);
  logic load_ok, ls_min_wrap, ms_min_wrap, ls_hr_wrap, day_end;
  logic [3:0] inc_ms_hr, inc_ls_hr, inc_ms_min, inc_ls_min;
  always_comb begin
    load_ok = new_current_time_ms_hr <= 4'd2 && new_current_time_ls_hr <= 4'd9 &&
              !(new_current_time_ms_hr == 4'd2 && new_current_time_ls_hr > 4'd3) &&
              new_current_time_ms_min <= 4'd5 && new_current_time_ls_min <= 4'd9;
    ls_min_wrap = current_time_ls_min == 4'd9;
    ms_min_wrap = ls_min_wrap && current_time_ms_min == 4'd5;
    ls_hr_wrap = ms_min_wrap && current_time_ls_hr == 4'd9;
    day_end = ms_min_wrap && current_time_ms_hr == 4'd2 && current_time_ls_hr == 4'd3;
    inc_ls_min = ls_min_wrap ? 4'd0 : current_time_ls_min + 4'd1;
    inc_ms_min = ms_min_wrap ? 4'd0 : ls_min_wrap ? current_time_ms_min + 4'd1 : current_time_ms_min;
    inc_ls_hr = (day_end || ls_hr_wrap) ? 4'd0 : ms_min_wrap ? current_time_ls_hr + 4'd1 : current_time_ls_hr;
    inc_ms_hr = day_end ? 4'd0 : ls_hr_wrap ? current_time_ms_hr + 4'd1 : current_time_ms_hr;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      current_time_ms_hr <= '0;
      current_time_ls_hr <= '0;
      current_time_ms_min <= '0;
      current_time_ls_min <= '0;
      day_rollover <= 1'b0;
      load_error <= 1'b0;
    end else begin
      day_rollover <= !load_new_c && one_minute && day_end;
      load_error <= load_new_c && !load_ok;
      if (load_new_c && load_ok) begin
        current_time_ms_hr <= new_current_time_ms_hr;
        current_time_ls_hr <= new_current_time_ls_hr;
        current_time_ms_min <= new_current_time_ms_min;
        current_time_ls_min <= new_current_time_ls_min;
      end else if (!load_new_c && one_minute) begin
        current_time_ms_hr <= inc_ms_hr;
        current_time_ls_hr <= inc_ls_hr;
        current_time_ms_min <= inc_ms_min;
        current_time_ls_min <= inc_ls_min;
      end
    end
  end
endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: scoreboard bench for time_counter using a minutes-of-day reference model
module tb_time_counter;
  logic clock = 1'b0, reset = 1'b0, one_minute = 1'b0, load_new_c = 1'b0;
  logic [3:0] n_mh = '0, n_lh = '0, n_mm = '0, n_lm = '0;
  logic [3:0] c_mh, c_lh, c_mm, c_lm;
  logic day_rollover, load_error;
  int errors = 0, checks = 0, mdl = 0;
  typedef struct { logic [15:0] t; logic dr; logic le; } exp_t;
  exp_t exp_q[$];
  wire [15:0] cur = {c_mh, c_lh, c_mm, c_lm};

  time_counter dut (
    .clock(clock), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
    .new_current_time_ms_hr(n_mh), .new_current_time_ls_hr(n_lh),
    .new_current_time_ms_min(n_mm), .new_current_time_ls_min(n_lm),
    .current_time_ms_hr(c_mh), .current_time_ls_hr(c_lh),
    .current_time_ms_min(c_mm), .current_time_ls_min(c_lm),
    .day_rollover(day_rollover), .load_error(load_error)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] digits(input int m);
    int h, mi;
    h = m / 60;
    mi = m % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10)};
  endfunction

  function automatic logic valid_time(input logic [15:0] d);
    int h;
    h = int'(d[15:12]) * 10 + int'(d[11:8]);
    return d[15:12] <= 2 && d[11:8] <= 9 && d[7:4] <= 5 && d[3:0] <= 9 && h < 24;
  endfunction

  // One clock of stimulus; the expected outcome is queued before the edge.
  task automatic drive(input logic ld, input logic [15:0] d, input logic tk);
    exp_t e;
    @(negedge clock);
    load_new_c = ld;
    {n_mh, n_lh, n_mm, n_lm} = d;
    one_minute = tk;
    e.dr = 1'b0;
    e.le = 1'b0;
    if (ld) begin
      if (valid_time(d))
        mdl = (int'(d[15:12]) * 10 + int'(d[11:8])) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
      else
        e.le = 1'b1;
    end else if (tk) begin
      e.dr = (mdl == 1439);
      mdl = (mdl + 1) % 1440;
    end
    e.t = digits(mdl);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    load_new_c = 1'b0;
    one_minute = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({cur, day_rollover, load_error} !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: got %h dr=%b le=%b, want 0000 dr=0 le=0", cur, day_rollover, load_error);
    end
    @(negedge clock);
    reset = 1'b1;
    mdl = 0;
  endtask

  task automatic test_load;
    exp_t e;
    drive(1'b1, 16'h1234, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if ({cur, day_rollover, load_error} !== {e.t, e.dr, e.le}) begin
      errors++;
      $display("FAIL load_1234: got %h dr=%b le=%b, want %h dr=%b le=%b", cur, day_rollover, load_error, e.t, e.dr, e.le);
    end
  endtask

  task automatic test_rollover;
    exp_t e;
    logic [16:0] st [4] = '{{1'b1, 16'h2358}, {1'b0, 16'h0}, {1'b0, 16'h0}, {1'b0, 16'hFFFF}};
    for (int i = 0; i < 4; i++) begin
      if (st[i][15:0] == 16'hFFFF) drive(1'b0, 16'h0, 1'b0);
      else drive(st[i][16], st[i][15:0], !st[i][16]);
      e = exp_q.pop_front();
      checks++;
      if ({cur, day_rollover, load_error} !== {e.t, e.dr, e.le}) begin
        errors++;
        $display("FAIL rollover[%0d]: got %h dr=%b le=%b, want %h dr=%b le=%b", i, cur, day_rollover, load_error, e.t, e.dr, e.le);
      end
    end
  endtask

  task automatic test_hour_carry;
    exp_t e;
    logic [15:0] ld_val [2] = '{16'h0959, 16'h1959};
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) drive(1'b1, ld_val[i / 2], 1'b0);
      else drive(1'b0, 16'h0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if ({cur, day_rollover, load_error} !== {e.t, e.dr, e.le}) begin
        errors++;
        $display("FAIL hour_carry[%0d]: got %h dr=%b le=%b, want %h dr=%b le=%b", i, cur, day_rollover, load_error, e.t, e.dr, e.le);
      end
    end
  endtask

  task automatic test_load_error;
    exp_t e;
    logic [15:0] bad [5] = '{16'h2400, 16'h1260, 16'h3000, 16'h1A00, 16'h120A};
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) drive(1'b1, bad[i / 2], 1'b0);
      else drive(1'b0, 16'h0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if ({cur, day_rollover, load_error} !== {e.t, e.dr, e.le}) begin
        errors++;
        $display("FAIL load_error[%0d]: got %h dr=%b le=%b, want %h dr=%b le=%b", i, cur, day_rollover, load_error, e.t, e.dr, e.le);
      end
    end
  endtask

  task automatic test_priority;
    exp_t e;
    logic [15:0] ld_val [3] = '{16'h1015, 16'h0707, 16'h2500};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ld_val[i], i != 0);
      e = exp_q.pop_front();
      checks++;
      if ({cur, day_rollover, load_error} !== {e.t, e.dr, e.le}) begin
        errors++;
        $display("FAIL priority[%0d]: got %h dr=%b le=%b, want %h dr=%b le=%b", i, cur, day_rollover, load_error, e.t, e.dr, e.le);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    drive(1'b1, 16'h2355, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 16'h0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if ({cur, day_rollover, load_error} !== {e.t, e.dr, e.le}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h dr=%b le=%b, want %h dr=%b le=%b", i, cur, day_rollover, load_error, e.t, e.dr, e.le);
      end
    end
  endtask

  task automatic test_hold;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h1959, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if ({cur, day_rollover, load_error} !== {e.t, e.dr, e.le}) begin
        errors++;
        $display("FAIL hold[%0d]: got %h dr=%b le=%b, want %h dr=%b le=%b", i, cur, day_rollover, load_error, e.t, e.dr, e.le);
      end
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    drive(1'b1, 16'h1542, 1'b0);
    void'(exp_q.pop_front());
    @(posedge clock);
    #3;
    reset = 1'b0;
    one_minute = 1'b1;
    load_new_c = 1'b1;
    {n_mh, n_lh, n_mm, n_lm} = 16'h0909;
    #1;
    checks++;
    if ({cur, day_rollover, load_error} !== 18'd0) begin
      errors++;
      $display("FAIL async_reset_now: got %h dr=%b le=%b, want 0000 dr=0 le=0", cur, day_rollover, load_error);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({cur, day_rollover, load_error} !== 18'd0) begin
      errors++;
      $display("FAIL async_reset_held: got %h dr=%b le=%b, want 0000 dr=0 le=0", cur, day_rollover, load_error);
    end
    @(negedge clock);
    one_minute = 1'b0;
    load_new_c = 1'b0;
    reset = 1'b1;
    mdl = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'h0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if ({cur, day_rollover, load_error} !== {e.t, e.dr, e.le}) begin
        errors++;
        $display("FAIL post_reset_tick[%0d]: got %h dr=%b le=%b, want %h dr=%b le=%b", i, cur, day_rollover, load_error, e.t, e.dr, e.le);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_rollover();
    test_hour_carry();
    test_load_error();
    test_priority();
    test_back_to_back();
    test_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 The block SHALL have no parameters; all widths and limits are fixed.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clock.
REQ-004 one_minute  input  1  one-cycle minute-advance strobe from the time generator (one_second-rate in fastwatch mode).
REQ-005 load_new_c  input  1  one-cycle request to load a new current time.
REQ-006 new_current_time_ms_hr, new_current_time_ls_hr, new_current_time_ms_min, new_current_time_ls_min  input  4 each  BCD digits of the time to load; sampled only when load_new_c=1.
REQ-007 current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min  output  4 each  registered BCD digits of the running time, 24-hour format.
REQ-008 day_rollover  output  1  registered one-cycle pulse on the 23:59 -> 00:00 transition.
REQ-009 load_error  output  1  registered one-cycle pulse when a load request carries an invalid time.

Function
REQ-010 The time SHALL always be a legal value in 00:00..23:59; every digit SHALL be BCD 0-9.
REQ-011 A load request is valid only when all of the following hold: ms_hr<=2; ls_hr<=9; ls_hr<=3 if ms_hr==2; ms_min<=5; ls_min<=9.
REQ-012 Valid load: on the edge sampling load_new_c=1, all four outputs SHALL take the new digits. Latency is one cycle.
REQ-013 Invalid load: the time SHALL hold and load_error SHALL be 1 for exactly the following cycle.
REQ-014 Increment: on the edge sampling one_minute=1 with load_new_c=0, the time SHALL advance by one minute. Latency is one cycle.
REQ-015 ls_min 9->0 SHALL carry into ms_min. ms_min 5->0 with ls_min 9 SHALL carry into the hour.
REQ-016 ls_hr 9->0 SHALL carry into ms_hr.
REQ-017 At 23:59 an increment SHALL yield 00:00 and assert day_rollover for exactly one cycle.
REQ-018 Load SHALL take priority over one_minute in the same cycle; that minute tick SHALL be discarded. This holds whether the load is valid or invalid.
REQ-019 With one_minute=0 and load_new_c=0, all outputs SHALL hold.
REQ-020 day_rollover and load_error SHALL be 0 in every cycle not covered by REQ-013 or REQ-017. The two SHALL never be 1 in the same cycle.
REQ-021 Back-to-back one_minute pulses on consecutive cycles SHALL each advance the time by one minute; no tick is lost.
REQ-022 Internally the block SHALL be a 4-digit BCD counter chain plus a load-validation comparator; no binary-to-BCD conversion is required.
REQ-023 Inputs other than reset SHALL be treated as synchronous to clock; no internal synchronizers.

Reset
REQ-024 While reset=0, all four time digits SHALL be 0 (00:00), and day_rollover and load_error SHALL be 0.
REQ-025 Reset assertion mid-operation, including in the same cycle as a load or tick, SHALL override it. No state change from that request SHALL survive.
REQ-026 After reset deasserts, the first rising edge SHALL obey REQ-012..REQ-019 normally.

Verification
REQ-027 Reset, then load 12:34 with load_new_c=1 for one cycle -> outputs 1,2,3,4 the next cycle; load_error=0.
REQ-028 Load 23:58, then apply two one_minute pulses -> 23:59, then 00:00. day_rollover=1 only in the 00:00 cycle.
REQ-029 Load 09:59, then apply one pulse -> 10:00. Load 19:59, then apply one pulse -> 20:00.
REQ-030 Load 24:00, then 12:60, then ms_hr=3 -> each time: time unchanged and load_error=1 for one cycle.
REQ-031 At 10:15, raise load_new_c (07:07) and one_minute in the same cycle -> 07:07, not 07:08 or 10:16.
REQ-032 At 15:42, drive reset low asynchronously between clock edges -> outputs read 00:00 before the next edge. Tick pulses during reset are ignored.
